// File: rtl/delta_walker.sv
// delta_walker: row-major raster sequencer. Emits one (dx, dy) delta beat per
// accepted transfer, together with the absolute (x, y) reached by that beat,
// so a downstream position accumulator can walk a COLS x ROWS grid.
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with the
// payload (dx, dy, x, y, last) held stable, until that beat transfers or the
// walk is aborted. The valid signal never depends combinationally on
// out_ready.
module delta_walker #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int COLS   = 4,
  parameter int ROWS   = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_dx,
  output logic [HEIGHT-1:0] out_dy,
  output logic [WIDTH-1:0]  out_x,
  output logic [HEIGHT-1:0] out_y,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last column / row indices, and the dx that rewinds x from COLS-1 to 0.
  localparam logic [WIDTH-1:0]  X_LAST  = WIDTH'(COLS - 1);
  localparam logic [HEIGHT-1:0] Y_LAST  = HEIGHT'(ROWS - 1);
  localparam logic [WIDTH-1:0]  DX_WRAP = WIDTH'(0) - X_LAST;

  state_t            state_q, state_d;
  logic              valid_d, last_d, busy_d, done_d;
  logic [WIDTH-1:0]  dx_d, x_d;
  logic [HEIGHT-1:0] dy_d, y_d;

  assign dbg_state = state_q;

  // Next state and next registered outputs; payload holds unless a step occurs.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    dx_d    = out_dx;
    dy_d    = out_dy;
    x_d     = out_x;
    y_d     = out_y;
    last_d  = out_last;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          valid_d = 1'b1;
          dx_d    = '0;
          dy_d    = '0;
          x_d     = '0;
          y_d     = '0;
          last_d  = (X_LAST == '0) && (Y_LAST == '0);
        end
      end
      RUN: begin
        if (abort || (out_valid && out_ready && out_last)) begin
          // Abort wins over a same-cycle transfer; only a clean finish pulses done.
          state_d = abort ? IDLE : DONE;
          done_d  = !abort;
          valid_d = 1'b0;
          dx_d    = '0;
          dy_d    = '0;
          x_d     = '0;
          y_d     = '0;
          last_d  = 1'b0;
        end else if (out_valid && out_ready) begin
          if (out_x == X_LAST) begin
            dx_d = DX_WRAP;
            dy_d = HEIGHT'(1);
            x_d  = '0;
            y_d  = out_y + HEIGHT'(1);
          end else begin
            dx_d = WIDTH'(1);
            dy_d = '0;
            x_d  = out_x + WIDTH'(1);
            y_d  = out_y;
          end
          last_d = (x_d == X_LAST) && (y_d == Y_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        dx_d    = '0;
        dy_d    = '0;
        x_d     = '0;
        y_d     = '0;
        last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_dx    <= '0;
      out_dy    <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_dx    <= dx_d;
      out_dy    <= dy_d;
      out_x     <= x_d;
      out_y     <= y_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_delta_walker.sv
// tb_delta_walker: directed bench for delta_walker. Stimulus pushes the
// expected beats into per-DUT queues; a negedge monitor pops and compares on
// every transfer and checks held payloads while stalled.
module tb_delta_walker;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT: 4 x 3 ----------------
  logic       m_start = 1'b0, m_abort = 1'b0, m_ready = 1'b1;
  logic       m_valid, m_last, m_busy, m_done;
  logic [7:0] m_dx, m_dy, m_x, m_y;
  logic [1:0] m_state;

  delta_walker #(.WIDTH(8), .HEIGHT(8), .COLS(4), .ROWS(3)) u_main (
    .clock(clock), .rst_n(rst_n), .start(m_start), .abort(m_abort),
    .out_valid(m_valid), .out_ready(m_ready), .out_dx(m_dx), .out_dy(m_dy),
    .out_x(m_x), .out_y(m_y), .out_last(m_last), .busy(m_busy),
    .done(m_done), .dbg_state(m_state)
  );

  // ---------------- degenerate DUTs: 1 x 3 and 1 x 1 ----------------
  logic       s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1;
  logic       a_valid, a_last, a_busy, a_done;
  logic [7:0] a_dx, a_dy, a_x, a_y;
  logic [1:0] a_state;
  logic       b_valid, b_last, b_busy, b_done;
  logic [7:0] b_dx, b_dy, b_x, b_y;
  logic [1:0] b_state;

  delta_walker #(.WIDTH(8), .HEIGHT(8), .COLS(1), .ROWS(3)) u_col (
    .clock(clock), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .out_valid(a_valid), .out_ready(s_ready), .out_dx(a_dx), .out_dy(a_dy),
    .out_x(a_x), .out_y(a_y), .out_last(a_last), .busy(a_busy),
    .done(a_done), .dbg_state(a_state)
  );

  delta_walker #(.WIDTH(8), .HEIGHT(8), .COLS(1), .ROWS(1)) u_one (
    .clock(clock), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .out_valid(b_valid), .out_ready(s_ready), .out_dx(b_dx), .out_dy(b_dy),
    .out_x(b_x), .out_y(b_y), .out_last(b_last), .busy(b_busy),
    .done(b_done), .dbg_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] mq[$];
  logic [32:0] aq[$];
  logic [32:0] bq[$];
  int m_xfer = 0, m_done_cnt = 0, m_hold = 0;
  int a_xfer = 0, a_done_cnt = 0, b_xfer = 0, b_done_cnt = 0;

  // Hand-computed 4 x 3 walk (dx = -3 mod 256 = 253 on row wraps).
  int tdx[12] = '{0, 1, 1, 1, 253, 1, 1, 1, 253, 1, 1, 1};
  int tdy[12] = '{0, 0, 0, 0, 1,   0, 0, 0, 1,   0, 0, 0};
  int tx[12]  = '{0, 1, 2, 3, 0,   1, 2, 3, 0,   1, 2, 3};
  int ty[12]  = '{0, 0, 0, 0, 1,   1, 1, 1, 2,   2, 2, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] pack(input int dx, input int dy, input int x, input int y, input bit last);
    return {8'(dx), 8'(dy), 8'(x), 8'(y), last};
  endfunction

  task automatic push_main();
    for (int k = 0; k < 12; k++) mq.push_back(pack(tdx[k], tdy[k], tx[k], ty[k], k == 11));
  endtask

  task automatic clear_counts();
    m_xfer = 0;
    m_done_cnt = 0;
    m_hold = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (rst_n) begin
      if (m_valid) begin
        check("m_beat_expected", 64'(mq.size() != 0), 64'd1);
        if (mq.size() != 0) begin
          if (m_ready) begin
            check("m_beat", {m_dx, m_dy, m_x, m_y, m_last}, mq.pop_front());
            m_xfer++;
          end else begin
            check("m_hold", {m_dx, m_dy, m_x, m_y, m_last}, mq[0]);
            m_hold++;
          end
        end
      end
      if (m_done) m_done_cnt++;
      if (a_valid) begin
        check("a_beat_expected", 64'(aq.size() != 0), 64'd1);
        if (aq.size() != 0) begin
          check("a_beat", {a_dx, a_dy, a_x, a_y, a_last}, aq.pop_front());
          a_xfer++;
        end
      end
      if (a_done) a_done_cnt++;
      if (b_valid) begin
        check("b_beat_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          check("b_beat", {b_dx, b_dy, b_x, b_y, b_last}, bq.pop_front());
          b_xfer++;
        end
      end
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Ends 1 time unit after the edge that samples start.
  task automatic start_main();
    @(posedge clock); #1 m_start = 1'b1;
    @(posedge clock); #1 m_start = 1'b0;
  endtask

  task automatic wait_m_done(output int cyc);
    cyc = 0;
    while (!m_done && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic end_of_walk(input string name, input int exp_xfer, input int exp_done);
    repeat (2) @(posedge clock);
    #1;
    check({name, "_xfers"}, 64'(m_xfer), 64'(exp_xfer));
    check({name, "_done_pulses"}, 64'(m_done_cnt), 64'(exp_done));
    check({name, "_idle"}, {m_valid, m_busy, m_done, m_state}, 64'd0);
    check({name, "_queue_empty"}, 64'(mq.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    repeat (3) @(posedge clock);
    #1;
    check("reset_main", {m_valid, m_dx, m_dy, m_x, m_y, m_last, m_busy, m_done, m_state}, 64'd0);
    check("reset_col", {a_valid, a_dx, a_dy, a_x, a_y, a_last, a_busy, a_done, a_state}, 64'd0);
    check("reset_one", {b_valid, b_dx, b_dy, b_x, b_y, b_last, b_busy, b_done, b_state}, 64'd0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // 1: full walk with ready held high, no bubbles.
    clear_counts(); push_main();
    start_main();
    check("t1_busy_run", {m_busy, m_valid, m_state}, {1'b1, 1'b1, 2'd1});
    wait_m_done(cyc);
    check("t1_walk_cycles", 64'(cyc), 64'd13);
    end_of_walk("t1", 12, 1);

    // 2: three-cycle stall on beat 4.
    clear_counts(); push_main();
    start_main();
    fork
      wait_m_done(cyc);
      begin
        repeat (4) @(posedge clock);
        #1 m_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 m_ready = 1'b1;
      end
    join
    check("t2_walk_cycles", 64'(cyc), 64'd16);
    check("t2_hold_cycles", 64'(m_hold), 64'd3);
    end_of_walk("t2", 12, 1);

    // 3: start mid-walk and during DONE is ignored.
    clear_counts(); push_main();
    start_main();
    fork
      wait_m_done(cyc);
      begin
        repeat (6) @(posedge clock);
        #1 m_start = 1'b1;
        @(posedge clock);
        #1 m_start = 1'b0;
      end
    join
    check("t3_walk_cycles", 64'(cyc), 64'd13);
    m_start = 1'b1;
    @(posedge clock); #1 m_start = 1'b0;
    end_of_walk("t3", 12, 1);

    // 4: abort on beat 6 (beat 6 still transfers), then a clean restart.
    clear_counts(); push_main();
    start_main();
    repeat (6) @(posedge clock);
    #1 m_abort = 1'b1;
    @(posedge clock);
    #1 m_abort = 1'b0;
    check("t4_abort_outputs", {m_valid, m_busy, m_dx, m_dy, m_x, m_y, m_last, m_state}, 64'd0);
    check("t4_abort_xfers", 64'(m_xfer), 64'd7);
    mq.delete();
    repeat (3) @(posedge clock);
    #1 check("t4_no_done", 64'(m_done_cnt), 64'd0);
    clear_counts(); push_main();
    start_main();
    wait_m_done(cyc);
    check("t4_restart_cycles", 64'(cyc), 64'd13);
    end_of_walk("t4r", 12, 1);

    // 5: asynchronous reset between edges, then a normal walk.
    clear_counts(); push_main();
    start_main();
    repeat (5) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", {m_valid, m_dx, m_dy, m_x, m_y, m_last, m_busy, m_done, m_state}, 64'd0);
    check("t5_xfers_before_reset", 64'(m_xfer), 64'd5);
    mq.delete();
    @(posedge clock); #1 rst_n = 1'b1;
    clear_counts(); push_main();
    start_main();
    wait_m_done(cyc);
    check("t5_walk_cycles", 64'(cyc), 64'd13);
    end_of_walk("t5", 12, 1);

    // 6: degenerate sizes, 1 x 3 and 1 x 1 in parallel.
    aq.push_back(pack(0, 0, 0, 0, 1'b0));
    aq.push_back(pack(0, 1, 0, 1, 1'b0));
    aq.push_back(pack(0, 1, 0, 2, 1'b1));
    bq.push_back(pack(0, 0, 0, 0, 1'b1));
    @(posedge clock); #1 s_start = 1'b1;
    @(posedge clock); #1 s_start = 1'b0;
    fork
      begin
        automatic int c = 0;
        while (!a_done && c < 50) begin
          @(negedge clock);
          c++;
        end
        check("t6_col_cycles", 64'(c), 64'd4);
      end
      begin
        automatic int c = 0;
        while (!b_done && c < 50) begin
          @(negedge clock);
          c++;
        end
        check("t6_one_cycles", 64'(c), 64'd2);
      end
    join
    repeat (3) @(posedge clock);
    #1;
    check("t6_col_xfers", 64'(a_xfer), 64'd3);
    check("t6_one_xfers", 64'(b_xfer), 64'd1);
    check("t6_col_done", 64'(a_done_cnt), 64'd1);
    check("t6_one_done", 64'(b_done_cnt), 64'd1);
    check("t6_idle", {a_valid, a_busy, a_state, b_valid, b_busy, b_state}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
